// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared definitions for the instruction memory bank
//   - opcode constants and peripheral select codes of the memory-mapped bus
//   - instruction word layout (opcode::dest::src1::src2)
//   - default program image restored on reset
//   - FSM state encoding used by instr_mem_bank
package instr_mem_pkg;

    localparam logic [7:0] OP_STOP      = 8'hFF;
    localparam logic [7:0] OP_MMULT     = 8'h00;
    localparam logic [7:0] OP_MADD      = 8'h01;
    localparam logic [7:0] OP_MSUB      = 8'h02;
    localparam logic [7:0] OP_MTRANS    = 8'h03;
    localparam logic [7:0] OP_MSCALE    = 8'h04;
    localparam logic [7:0] OP_MSCALEIMM = 8'h05;
    localparam logic [7:0] OP_INTADD    = 8'h10;
    localparam logic [7:0] OP_INTSUB    = 8'h11;
    localparam logic [7:0] OP_INTMULT   = 8'h12;
    localparam logic [7:0] OP_INTDIV    = 8'h13;

    // Peripheral select codes carried in address[15:12]
    localparam logic [3:0] SEL_CTRL   = 4'h0;
    localparam logic [3:0] SEL_INSTR  = 4'h1;
    localparam logic [3:0] SEL_MAT_A  = 4'h2;
    localparam logic [3:0] SEL_MAT_B  = 4'h3;
    localparam logic [3:0] SEL_RESULT = 4'h4;
    localparam logic [3:0] SEL_ALU    = 4'h5;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    localparam instr_t STOP_WORD = '{opcode: OP_STOP, dest: 8'h00, src1: 8'h00, src2: 8'h00};

    // Program inherited from the fixed 10-word ROM; everything past it is STOP
    localparam int IMG_LEN = 10;
    localparam instr_t DEFAULT_IMAGE [IMG_LEN] = '{
        32'h01020001,
        32'hFF000000,
        32'h00030102,
        32'h02040301,
        32'h03050400,
        32'h04060503,
        32'h10070605,
        32'h11080706,
        32'h12090807,
        32'hFF000000
    };

    typedef enum logic [2:0] {
        IDLE,
        READ,
        HOLD,
        WRITE,
        RELEASE
    } state_t;

    function automatic logic [31:0] default_word(input int idx);
        return (idx < IMG_LEN) ? DEFAULT_IMAGE[4'(idx)] : STOP_WORD;
    endfunction

endpackage

// File: rtl/instr_mem_bank_array.sv
// instr_mem_array: instruction word storage with reset image load and wrapped line read
//   Clk, nReset : clock, asynchronous active-low reset (reloads default image)
//   we, waddr, wdata : single-word write port
//   raddr : first word index of the fetch line
//   line  : LANES consecutive words starting at raddr, wrapping at DEPTH
//   perr  : some word of the line fails its parity check
// Optional: INSTR_MEM_PARITY_EN adds an even-parity bit per stored word.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 256,
    parameter int BUS_W  = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int LANES = BUS_W / WORD_W
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BUS_W-1:0]  line,
    output logic              perr
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WORD_W'(default_word(i));
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Index arithmetic is AW bits wide, so raddr + k wraps modulo DEPTH
    always_comb begin
        line = '0;
        for (int k = 0; k < LANES; k++) line[k*WORD_W +: WORD_W] = mem[raddr + AW'(k)];
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= ^WORD_W'(default_word(i));
        end else if (we) begin
            par[waddr] <= ^wdata;
        end
    end

    always_comb begin
        perr = 1'b0;
        for (int k = 0; k < LANES; k++) perr = perr | ((^mem[raddr + AW'(k)]) != par[raddr + AW'(k)]);
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/instr_mem_bank.sv
// instr_mem_bank: bus-loadable instruction memory serving LANES-word fetch lines
//   Clk, nReset : clock, asynchronous active-low reset
//   address     : [15:12] peripheral select, [11:0] word index
//   nRead       : active-low read request, held through the fetch
//   nWrite      : active-low write request, one word per strobe
//   DataIn      : word to be written
//   DataOut     : fetch line, word k at [k*WORD_W +: WORD_W]
//   DataValid   : DataOut holds a valid line
//   AddrErr     : sticky; set by out-of-range or read+write, cleared by next good access
//   ParityErr   : stored-word parity mismatch (only with INSTR_MEM_PARITY_EN, else 0)
module instr_mem_bank
    import instr_mem_pkg::*;
#(
    parameter int         WORD_W = 32,
    parameter int         DEPTH  = 256,
    parameter int         BUS_W  = 256,
    parameter logic [3:0] SELECT = 4'h1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [15:0]       address,
    input  logic              nRead,
    input  logic              nWrite,
    input  logic [WORD_W-1:0] DataIn,
    output logic [BUS_W-1:0]  DataOut,
    output logic              DataValid,
    output logic              AddrErr,
    output logic              ParityErr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [12:0] DEPTH13 = 13'(DEPTH);

    state_t state;
    logic [11:0] idx;
    logic [BUS_W-1:0] line;
    logic perr;
    logic sel;
    logic idx_ok;
    logic req_ok;

    assign sel    = address[15:12] == SELECT;
    assign idx_ok = {1'b0, idx} < DEPTH13;
    assign req_ok = {1'b0, address[11:0]} < DEPTH13;

    instr_mem_array #(
        .WORD_W(WORD_W),
        .DEPTH (DEPTH),
        .BUS_W (BUS_W)
    ) u_array (
        .Clk   (Clk),
        .nReset(nReset),
        .we    (state == WRITE && idx_ok),
        .waddr (AW'(idx)),
        .wdata (DataIn),
        .raddr (AW'(idx)),
        .line  (line),
        .perr  (perr)
    );

    // The error flag is resolved when the access is accepted, so a good
    // access clears it and a bad one sets it at the same edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            idx       <= '0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            AddrErr   <= 1'b0;
            ParityErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && !(nRead && nWrite)) begin
                        idx <= address[11:0];
                        if (!nRead && !nWrite) begin
                            AddrErr <= 1'b1;
                            state   <= RELEASE;
                        end else begin
                            AddrErr <= !req_ok;
                            state   <= nRead ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    DataOut   <= idx_ok ? line : '0;
                    DataValid <= idx_ok;
                    ParityErr <= idx_ok && perr;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (nRead) begin
                        DataOut   <= '0;
                        DataValid <= 1'b0;
                        ParityErr <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WRITE: state <= RELEASE;
                RELEASE: begin
                    if (nRead && nWrite) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
